// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART receive path.
//   rx_state_t      receive FSM state encoding
//   OVERSAMPLE_DEF  default rx_clk ticks per bit period
//   DATA_BITS_DEF   default data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_sync_edge.sv
// uart_sync_edge: two-flop synchroniser for an asynchronous level, with an
// optional rising-edge detector on the synchronised signal.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input
//   q      out  EDGE=0: synchronised level
//               EDGE=1: one-clk pulse on each rising edge of the synced level
// Parameters:
//   RST_VAL  reset value of the synchroniser flops (idle level of d)
//   EDGE     selects the output form
module uart_sync_edge #(
  parameter bit RST_VAL = 1'b0,
  parameter bit EDGE    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic prev;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= RST_VAL;
        else        prev <= s2;
      end

      assign q = s2 & ~prev;
    end else begin : g_level
      assign q = s2;
    end
  endgenerate

endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receive deserializer. Runs on clk and uses rx_clk
// (16x-baud oversample clock) only as a rate reference; every FSM step is
// gated by a one-clk tick taken from the synchronised rising edge of rx_clk.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   rx_clk      in   oversample reference from the baud generator
//   rx          in   serial line, idle high, asynchronous
//   rx_data     out  received word, stable while rx_valid=1
//   rx_valid    out  word available, held until accepted
//   rx_ready    in   consumer accepts when rx_valid & rx_ready
//   frame_err   out  stop bit of the delivered word was sampled low
//   parity_err  out  parity mismatch on the delivered word
//   overrun     out  one-clk pulse: a completed word was dropped
//   busy        out  FSM is outside IDLE
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic tick;
  logic rx_s;

  uart_sync_edge #(.RST_VAL(1'b0), .EDGE(1'b1)) u_sync_clk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_clk),
    .q     (tick)
  );

  uart_sync_edge #(.RST_VAL(1'b1), .EDGE(1'b0)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;
  logic                 complete;

  // Receive FSM; busy is kept in step with every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      perr_q  <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
              perr_q  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) state <= PARITY_EN ? PARITY : STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            perr_q <= (^shreg) ^ rx_s ^ PARITY_ODD;
            state  <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Frame completes on the stop-bit sample tick; delivery lands on the next clk.
  assign complete = tick && (state == STOP) && (cnt == CNT_LAST);

  // Output holding register. An accept in the same cycle as a completion
  // frees the slot, so the new word replaces the old one without overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          rx_valid   <= 1'b1;
          frame_err  <= ~rx_s;
          parity_err <= perr_q;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
module tb_uart_rx_deser;

  localparam int BIT_NS = 640;   // 16 rx_clk periods of 40 ns

  logic       clk;
  logic       rst_n;
  logic       rx_clk;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  logic       rx_p;
  logic       rx_ready_p;
  logic [7:0] rx_data_p;
  logic       rx_valid_p;
  logic       frame_err_p;
  logic       parity_err_p;
  logic       overrun_p;
  logic       busy_p;

  int n_checks = 0;
  int n_fail   = 0;

  int         acc_cnt = 0;
  logic [7:0] acc_data;
  logic       acc_ferr;
  logic       acc_perr;
  int         ovr_cnt = 0;
  int         p_acc_cnt = 0;
  logic [7:0] p_acc_data;
  logic       p_acc_ferr;
  logic       p_acc_perr;

  uart_rx_deser #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_clk     (rx_clk),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  uart_rx_deser #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_clk     (rx_clk),
    .rx         (rx_p),
    .rx_data    (rx_data_p),
    .rx_valid   (rx_valid_p),
    .rx_ready   (rx_ready_p),
    .frame_err  (frame_err_p),
    .parity_err (parity_err_p),
    .overrun    (overrun_p),
    .busy       (busy_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial rx_clk = 1'b0;
  always #20 rx_clk = ~rx_clk;

  // Observe handshakes and overrun pulses on the falling edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      acc_cnt  = acc_cnt + 1;
      acc_data = rx_data;
      acc_ferr = frame_err;
      acc_perr = parity_err;
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (rx_valid_p && rx_ready_p) begin
      p_acc_cnt  = p_acc_cnt + 1;
      p_acc_data = rx_data_p;
      p_acc_ferr = frame_err_p;
      p_acc_perr = parity_err_p;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic line_set(input bit to_p, input logic v);
    if (to_p) rx_p = v;
    else      rx   = v;
  endtask

  // Stop bit driven low is held only past its mid-bit sample, so the
  // remaining low does not outlast a false start's mid-bit check.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit to_p, input logic par);
    line_set(to_p, 1'b0);
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      line_set(to_p, d[i]);
      #BIT_NS;
    end
    if (to_p) begin
      rx_p = par;
      #BIT_NS;
    end
    line_set(to_p, stop);
    if (stop) #BIT_NS;
    else      #480;
    line_set(to_p, 1'b1);
    #(2 * BIT_NS);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rx_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00)   begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_checks++; if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    n_checks++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (busy_p !== 1'b0)     begin n_fail++; $display("FAIL reset_busy_p: got %b want 0", busy_p); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #(2 * BIT_NS);
  endtask

  task automatic test_basic;
    int a0;
    a0 = acc_cnt;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    n_checks++; if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", acc_cnt - a0); end
    n_checks++; if (acc_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", acc_data); end
    n_checks++; if (acc_ferr !== 1'b0)  begin n_fail++; $display("FAIL basic_ferr: got %b want 0", acc_ferr); end
    n_checks++; if (acc_perr !== 1'b0)  begin n_fail++; $display("FAIL basic_perr: got %b want 0", acc_perr); end
    n_checks++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", rx_valid); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    int a0;
    a0 = acc_cnt;
    rx = 1'b0;
    #120;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    rx = 1'b1;
    #480;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL glitch_busy_idle: got %b want 0", busy); end
    n_checks++; if (acc_cnt - a0 !== 0) begin n_fail++; $display("FAIL glitch_no_word: got %0d want 0", acc_cnt - a0); end
    n_checks++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    #BIT_NS;
  endtask

  task automatic test_frame_err;
    int a0;
    a0 = acc_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    n_checks++; if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", acc_cnt - a0); end
    n_checks++; if (acc_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data: got %h want 3c", acc_data); end
    n_checks++; if (acc_ferr !== 1'b1)  begin n_fail++; $display("FAIL ferr_flag: got %b want 1", acc_ferr); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL ferr_rearm: got %b want 0", busy); end
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    n_checks++; if (acc_cnt - a0 !== 2) begin n_fail++; $display("FAIL ferr_next_count: got %0d want 2", acc_cnt - a0); end
    n_checks++; if (acc_data !== 8'h55) begin n_fail++; $display("FAIL ferr_next_data: got %h want 55", acc_data); end
    n_checks++; if (acc_ferr !== 1'b0)  begin n_fail++; $display("FAIL ferr_next_flag: got %b want 0", acc_ferr); end
  endtask

  task automatic test_break;
    int a0;
    a0 = acc_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++; if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL break_count: got %0d want 1", acc_cnt - a0); end
    n_checks++; if (acc_data !== 8'h00) begin n_fail++; $display("FAIL break_data: got %h want 00", acc_data); end
    n_checks++; if (acc_ferr !== 1'b1)  begin n_fail++; $display("FAIL break_ferr: got %b want 1", acc_ferr); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL break_rearm: got %b want 0", busy); end
  endtask

  task automatic test_parity;
    int a0;
    a0 = p_acc_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    n_checks++; if (p_acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL par_bad_count: got %0d want 1", p_acc_cnt - a0); end
    n_checks++; if (p_acc_data !== 8'h07) begin n_fail++; $display("FAIL par_bad_data: got %h want 07", p_acc_data); end
    n_checks++; if (p_acc_perr !== 1'b1)  begin n_fail++; $display("FAIL par_bad_perr: got %b want 1", p_acc_perr); end
    n_checks++; if (p_acc_ferr !== 1'b0)  begin n_fail++; $display("FAIL par_bad_ferr: got %b want 0", p_acc_ferr); end
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    n_checks++; if (p_acc_cnt - a0 !== 2) begin n_fail++; $display("FAIL par_good_count: got %0d want 2", p_acc_cnt - a0); end
    n_checks++; if (p_acc_perr !== 1'b0)  begin n_fail++; $display("FAIL par_good_perr: got %b want 0", p_acc_perr); end
  endtask

  task automatic test_overrun;
    int o0;
    int a0;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    n_checks++; if (rx_valid !== 1'b1)  begin n_fail++; $display("FAIL ovr_first_valid: got %b want 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h11)  begin n_fail++; $display("FAIL ovr_first_data: got %h want 11", rx_data); end
    n_checks++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL ovr_none_yet: got %0d want 0", ovr_cnt - o0); end
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    n_checks++; if (rx_data !== 8'h11)  begin n_fail++; $display("FAIL ovr_data_kept: got %h want 11", rx_data); end
    n_checks++; if (rx_valid !== 1'b1)  begin n_fail++; $display("FAIL ovr_valid_held: got %b want 1", rx_valid); end
    n_checks++; if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulse_count: got %0d want 1", ovr_cnt - o0); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ovr_ferr: got %b want 0", frame_err); end
    a0 = acc_cnt;
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL ovr_accept_drop: got %b want 0", rx_valid); end
    n_checks++; if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL ovr_accept_count: got %0d want 1", acc_cnt - a0); end
    n_checks++; if (acc_data !== 8'h11) begin n_fail++; $display("FAIL ovr_accept_data: got %h want 11", acc_data); end
  endtask

  task automatic test_reset_mid;
    int a0;
    logic [7:0] d;
    d = 8'hF0;
    a0 = acc_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      #BIT_NS;
    end
    rx = d[4];
    #320;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_checks++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL rmid_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL rmid_data: got %h want 00", rx_data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rmid_ferr: got %b want 0", frame_err); end
    rx = 1'b1;
    #200;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #(2 * BIT_NS);
    n_checks++; if (acc_cnt - a0 !== 0) begin n_fail++; $display("FAIL rmid_no_word: got %0d want 0", acc_cnt - a0); end
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    n_checks++; if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL rmid_after_count: got %0d want 1", acc_cnt - a0); end
    n_checks++; if (acc_data !== 8'h81) begin n_fail++; $display("FAIL rmid_after_data: got %h want 81", acc_data); end
    n_checks++; if (acc_ferr !== 1'b0)  begin n_fail++; $display("FAIL rmid_after_ferr: got %b want 0", acc_ferr); end
  endtask

  initial begin
    rx         = 1'b1;
    rx_p       = 1'b1;
    rx_ready   = 1'b1;
    rx_ready_p = 1'b1;
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_break;
    test_parity;
    test_overrun;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
